// File: rtl/rnn_cell_accel.sv
// rnn_cell_accel: single-step Elman RNN cell behind a simple register bus.
// Define RNN_RELU_EN for ReLU activation; the default build uses identity.
module rnn_cell_accel #(
  parameter int IN_DIM  = 2,
  parameter int HID_DIM = 4,
  parameter int DATA_W  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam int CW = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WMUL, S_RMUL, S_ADD, S_ACT, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [DATA_W-1:0] r_x      [IN_DIM];
  logic signed [DATA_W-1:0] r_w      [IN_DIM][HID_DIM];
  logic signed [DATA_W-1:0] r_r      [HID_DIM][HID_DIM];
  logic signed [DATA_W-1:0] r_b      [HID_DIM];
  logic signed [DATA_W-1:0] r_h      [HID_DIM];
  logic signed [DATA_W-1:0] r_hidden [HID_DIM];
  logic signed [DATA_W-1:0] r_wv     [HID_DIM];
  logic signed [DATA_W-1:0] r_rv     [HID_DIM];
  logic [CW-1:0]            r_cnt;

  logic w_last, w_cfg_ok, w_start, w_busy, w_done;
  logic w_wrdy, w_rrdy;
  logic signed [DATA_W-1:0] w_wsum, w_rsum;

  function automatic logic signed [DATA_W-1:0] act(
    input logic signed [DATA_W-1:0] v
  );
`ifdef RNN_RELU_EN
    return (v[DATA_W-1] || v == '0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign w_last  = (r_cnt == CW'(HID_DIM-1));
  assign w_start = write && (addr == 32'd0) && w_cfg_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start) w_next = S_START;
      S_START:        w_next = S_WMUL;
      S_WMUL:         if (w_wrdy) w_next = S_RMUL;
      S_RMUL:         if (w_rrdy) w_next = S_ADD;
      S_ADD:          w_next = S_ACT;
      S_ACT:          w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cfg_ok = (r_state == S_IDLE) || (r_state == S_DONE);
    w_done   = (r_state == S_DONE);
    w_busy   = !w_cfg_ok;
    w_wrdy   = (r_state == S_WMUL) && w_last;
    w_rrdy   = (r_state == S_RMUL) && w_last;
  end

  // One output column per cycle; sums wrap at DATA_W bits.
  always_comb begin
    w_wsum = '0;
    w_rsum = '0;
    for (int i = 0; i < IN_DIM; i++)
      w_wsum = w_wsum + r_x[i] * r_w[i][r_cnt];
    for (int k = 0; k < HID_DIM; k++)
      w_rsum = w_rsum + r_h[k] * r_r[k][r_cnt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      for (int i = 0; i < IN_DIM; i++) begin
        r_x[i] <= '0;
        for (int j = 0; j < HID_DIM; j++) r_w[i][j] <= '0;
      end
      for (int j = 0; j < HID_DIM; j++) begin
        r_b[j]      <= '0;
        r_h[j]      <= '0;
        r_hidden[j] <= '0;
        r_wv[j]     <= '0;
        r_rv[j]     <= '0;
        for (int k = 0; k < HID_DIM; k++) r_r[j][k] <= '0;
      end
    end else begin
      if (write && w_cfg_ok) begin
        unique case (1'b1)
          addr == 32'd1:
            for (int i = 0; i < IN_DIM; i++)
              if (data_in[31:16] == 16'(i))
                r_x[i] <= data_in[DATA_W-1:0];
          addr == 32'd2:
            for (int i = 0; i < IN_DIM; i++)
              for (int j = 0; j < HID_DIM; j++)
                if (data_in[31:24] == 8'(i) && data_in[23:16] == 8'(j))
                  r_w[i][j] <= data_in[DATA_W-1:0];
          addr == 32'd3:
            for (int k = 0; k < HID_DIM; k++)
              for (int j = 0; j < HID_DIM; j++)
                if (data_in[31:24] == 8'(k) && data_in[23:16] == 8'(j))
                  r_r[k][j] <= data_in[DATA_W-1:0];
          addr == 32'd4:
            for (int j = 0; j < HID_DIM; j++)
              if (data_in[31:16] == 16'(j))
                r_b[j] <= data_in[DATA_W-1:0];
          default: ;
        endcase
      end
      case (r_state)
        S_START: begin
          r_cnt <= '0;
          for (int j = 0; j < HID_DIM; j++) begin
            r_wv[j] <= '0;
            r_rv[j] <= '0;
          end
        end
        S_WMUL: begin
          r_wv[r_cnt] <= w_wsum;
          r_cnt       <= w_last ? '0 : r_cnt + 1'b1;
        end
        S_RMUL: begin
          r_rv[r_cnt] <= w_rsum;
          r_cnt       <= w_last ? '0 : r_cnt + 1'b1;
        end
        S_ADD:
          for (int j = 0; j < HID_DIM; j++)
            r_hidden[j] <= r_wv[j] + r_rv[j] + r_b[j];
        S_ACT:
          for (int j = 0; j < HID_DIM; j++)
            r_h[j] <= act(r_hidden[j]);
        default: ;
      endcase
    end
  end

  always_comb begin
    data_out = '0;
    if (read) begin
      if (addr == 32'd0) data_out = {30'b0, w_busy, w_done};
      for (int j = 0; j < HID_DIM; j++)
        if (addr == 32'(5 + j))
          data_out = {{(32-DATA_W){r_h[j][DATA_W-1]}}, r_h[j]};
    end
  end

endmodule

// File: tb/tb_rnn_cell_accel.sv
// tb_rnn_cell_accel: scoreboard bench for the RNN cell accelerator.
// Expected hidden states come from a wrapping 16-bit reference model.
module tb_rnn_cell_accel;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;

  int n_chk = 0;
  int n_err = 0;

  logic signed [15:0] mx [2];
  logic signed [15:0] mw [2][4];
  logic signed [15:0] mr [4][4];
  logic signed [15:0] mb [4];
  logic signed [15:0] mh [4];
  logic [31:0] exp_q [$];

  int xt [2]    = '{2, -3};
  int wt [2][4] = '{'{2, -10, -10, 3}, '{6, 9, 12, 1}};
  int rt [4][4] = '{'{-2, -3, -5, -3}, '{-1, 10, -2, -6},
                    '{4, 11, 3, -12}, '{-11, -4, 3, -1}};
  int bt [4]    = '{-2, -2, -1, -1};

  rnn_cell_accel dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act_v,
                       input logic [31:0] exp_v);
    n_chk++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act_v, exp_v);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    write = 1'b1;
    addr = a;
    data_in = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
    read = 1'b1;
    addr = a;
    #1 v = data_out;
    read = 1'b0;
  endtask

  function automatic logic signed [15:0] m_act(input logic signed [15:0] v);
`ifdef RNN_RELU_EN
    return (v > 16'sd0) ? v : 16'sd0;
`else
    return v;
`endif
  endfunction

  function automatic void model_step();
    logic signed [15:0] nh [4];
    logic signed [15:0] wv, rv;
    for (int j = 0; j < 4; j++) begin
      wv = '0;
      rv = '0;
      for (int i = 0; i < 2; i++) wv = wv + mx[i] * mw[i][j];
      for (int k = 0; k < 4; k++) rv = rv + mh[k] * mr[k][j];
      nh[j] = m_act(wv + rv + mb[j]);
    end
    for (int j = 0; j < 4; j++) begin
      mh[j] = nh[j];
      exp_q.push_back({{16{nh[j][15]}}, nh[j]});
    end
  endfunction

  // Polls status from the current negedge until done, cycle-bounded.
  task automatic poll_done(input int start_cyc, output int cyc);
    cyc = start_cyc;
    read = 1'b1;
    addr = 32'd0;
    #1;
    while (data_out[0] !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    read = 1'b0;
  endtask

  task automatic compare_h(input string tag);
    logic [31:0] v;
    for (int j = 0; j < 4; j++) begin
      bus_rd(32'(5 + j), v);
      if (exp_q.size() == 0) check({tag, "_sb_empty"}, v, 32'hDEAD_BEEF);
      else check($sformatf("%s_h%0d", tag, j), v, exp_q.pop_front());
    end
  endtask

  task automatic run_step(input string tag);
    logic [31:0] v;
    int cyc;
    model_step();
    bus_wr(32'd0, 32'd0);
    bus_rd(32'd0, v);
    check({tag, "_busy"}, v, 32'd2);
    @(negedge clk);
    poll_done(1, cyc);
    check({tag, "_latency"}, 32'(cyc), 32'd11);
    bus_rd(32'd0, v);
    check({tag, "_done"}, v, 32'd1);
    compare_h(tag);
  endtask

  initial begin
    logic [31:0] v;
    int cyc;
    for (int i = 0; i < 2; i++) begin
      mx[i] = '0;
      for (int j = 0; j < 4; j++) mw[i][j] = '0;
    end
    for (int j = 0; j < 4; j++) begin
      mb[j] = '0;
      mh[j] = '0;
      for (int k = 0; k < 4; k++) mr[j][k] = '0;
    end

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus_rd(32'd0, v);
    check("rst_status", v, 32'd0);
    for (int j = 0; j < 4; j++) begin
      bus_rd(32'(5 + j), v);
      check($sformatf("rst_h%0d", j), v, 32'd0);
    end
    @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      bus_wr(32'd1, {16'(i), 16'(xt[i])});
      mx[i] = 16'(xt[i]);
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) begin
        bus_wr(32'd2, {8'(i), 8'(j), 16'(wt[i][j])});
        mw[i][j] = 16'(wt[i][j]);
      end
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) begin
        bus_wr(32'd3, {8'(k), 8'(j), 16'(rt[k][j])});
        mr[k][j] = 16'(rt[k][j]);
      end
    for (int j = 0; j < 4; j++) begin
      bus_wr(32'd4, {16'(j), 16'(bt[j])});
      mb[j] = 16'(bt[j]);
    end
    bus_wr(32'd2, {8'd2, 8'd0, 16'd77});
    bus_wr(32'd3, {8'd0, 8'd4, 16'd77});
    bus_wr(32'd1, {16'd2, 16'd77});
    bus_wr(32'd9, 32'h1234_5678);

    bus_rd(32'd9, v);
    check("rd_unmapped", v, 32'd0);
    bus_rd(32'd4, v);
    check("rd_bias_addr", v, 32'd0);

    run_step("step1");
    bus_rd(32'd5, v);
`ifdef RNN_RELU_EN
    check("step1_h0_const", v, 32'd0);
`else
    check("step1_h0_const", v, 32'hFFFF_FFF0);
`endif
    bus_rd(32'd8, v);
    check("step1_h3_const", v, 32'd2);
    addr = 32'd8;
    read = 1'b0;
    #1 check("rd_idle_zero", data_out, 32'd0);
    @(negedge clk);

    // Step 2 with writes and a second start while busy; all must be ignored.
    model_step();
    bus_wr(32'd0, 32'd0);
    bus_wr(32'd1, {16'd0, 16'd100});
    bus_wr(32'd0, 32'd0);
    bus_wr(32'd4, {16'd3, 16'd500});
    poll_done(3, cyc);
    check("step2_latency", 32'(cyc), 32'd11);
    compare_h("step2");
    @(negedge clk);

    bus_wr(32'd1, {16'd0, 16'hFFFB});
    mx[0] = -16'sd5;
    run_step("step3");
    @(negedge clk);

    bus_wr(32'd0, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus_rd(32'd0, v);
    check("midrst_status", v, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_rd(32'd0, v);
    check("postrst_status", v, 32'd0);
    for (int j = 0; j < 4; j++) begin
      bus_rd(32'(5 + j), v);
      check($sformatf("postrst_h%0d", j), v, 32'd0);
      mh[j] = '0;
      mb[j] = '0;
      for (int k = 0; k < 4; k++) mr[j][k] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      mx[i] = '0;
      for (int j = 0; j < 4; j++) mw[i][j] = '0;
    end
    @(negedge clk);
    bus_wr(32'd4, {16'd0, 16'd5});
    bus_wr(32'd4, {16'd1, 16'hFFF9});
    bus_wr(32'd4, {16'd3, 16'd3});
    mb[0] = 16'sd5;
    mb[1] = -16'sd7;
    mb[3] = 16'sd3;
    run_step("step4");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
